instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC fetched first after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 stall  input  1  SHALL mean the decode stage cannot accept a new instruction this cycle.
REQ-005 branch_taken  input  1  SHALL mean the instruction held in the output register redirects to branch_target.
REQ-006 branch_target  input  32  SHALL be the absolute byte address for a taken branch.
REQ-007 jump  input  1  SHALL mean the held instruction is J/JAL.
REQ-008 jump_addr  input  26  SHALL be the raw 26-bit J-format address field.
REQ-009 imem_req  output  1  SHALL be the fetch request to instruction memory.
REQ-010 imem_addr  output  32  SHALL be the fetch byte address.
REQ-011 imem_ready  input  1  SHALL complete a transfer in any cycle where imem_req=1.
REQ-012 imem_rdata  input  32  SHALL be the instruction word, valid when imem_req&imem_ready.
REQ-013 instruction  output  32  SHALL be the registered instruction word driven to the decode stage.
REQ-014 pc_plus4  output  32  SHALL be the address of the held instruction plus 4.
REQ-015 valid  output  1  SHALL mark instruction/pc_plus4 as meaningful.

Function
REQ-016 The FSM SHALL have states BOOT, REQ, HOLD and DISCARD; imem_req SHALL be 1 exactly in REQ and DISCARD.
REQ-017 BOOT SHALL last one cycle after reset release, then move to REQ.
REQ-018 Once imem_req is asserted, it and imem_addr SHALL stay stable until imem_ready=1, regardless of stall or redirect.
REQ-019 In REQ, imem_addr SHALL equal pc; on the handshake, pc SHALL advance by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-020 Handshake in REQ with stall=0 or valid=0 SHALL load instruction=imem_rdata, pc_plus4=pc+4, valid=1 next cycle (1-cycle latency).
REQ-021 Handshake in REQ with stall=1 and valid=1 SHALL load a one-entry skid register and move to HOLD; outputs SHALL stay unchanged.
REQ-022 HOLD SHALL deassert imem_req; on the first cycle with stall=0, the skid entry SHALL move to the output register and the FSM SHALL return to REQ.
REQ-023 While stall=1 and valid=1, instruction, pc_plus4 and valid SHALL hold their values.
REQ-024 A redirect SHALL be taken only when valid=1, stall=0 and (jump or branch_taken); jump SHALL have priority over branch_taken.
REQ-025 The jump target SHALL be {pc_plus4[31:28], jump_addr, 2'b00}; the branch target SHALL be branch_target unmodified.
REQ-026 No delay slot: a redirect SHALL clear valid and the skid entry next cycle and load pc with the target.
REQ-027 A redirect in REQ without imem_ready, or in HOLD, SHALL be handled as follows: in REQ, move to DISCARD holding the old address and saving the target; in HOLD, drop the skid entry and go to REQ at the target.
REQ-028 A redirect in the same cycle as a REQ handshake SHALL drop imem_rdata and fetch the target next from REQ.
REQ-029 In DISCARD, the returned word SHALL be dropped; on imem_ready, pc SHALL take the saved target and the FSM SHALL go to REQ.
REQ-030 A redirect while in DISCARD SHALL overwrite the saved target (latest wins).

Reset
REQ-031 While rst_n=0: pc=RESET_PC, state=BOOT, imem_req=0, imem_addr=RESET_PC, instruction=0, pc_plus4=0, valid=0, skid empty.
REQ-032 Reset asserted mid-transfer, including in DISCARD, SHALL abandon the transfer immediately with no output glitch beyond the reset values.

Structure
REQ-033 FSM state encodings, the RESET_PC default and the J-opcode values (6'b000010, 6'b000011) SHALL live in a shared package, mips_pkg.
REQ-034 The PC register and next-PC/target mux SHALL be one sub-module, instruction_fetch_pc; the FSM, skid buffer and output register SHALL remain in instruction_fetch.

Verification
REQ-035 Reset, imem_ready tied 1, stall=0 -> imem_addr 0,4,8 on consecutive cycles; valid rises the cycle after the first handshake; pc_plus4=4,8,12.
REQ-036 stall=1 for 3 cycles with an outstanding handshake -> word captured in skid, HOLD with imem_req=0, outputs frozen; after stall falls, skid word appears with no loss or duplication.
REQ-037 Held pc_plus4=32'h4000_0010, jump=1, jump_addr=26'h0000100 -> next fetch address 32'h4000_0400, valid=0 for one cycle.
REQ-038 branch_taken=1, branch_target=32'h0000_0080 while imem_ready=0 for 4 cycles -> imem_addr stays at the old value until ready, returned word dropped, next fetch at 32'h80.
REQ-039 jump=1 and branch_taken=1 together -> jump target fetched; a redirect with stall=1 -> ignored.
REQ-040 rst_n dropped in DISCARD -> all outputs reach reset values asynchronously; fetch restarts at RESET_PC after BOOT.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions.
//   fetch_state_t    : instruction fetch FSM state encoding
//   DEFAULT_RESET_PC : default first fetch address after reset
//   OP_J / OP_JAL    : J-format opcodes
//   jump_target()    : J-format target from the upper PC bits and the 26-bit field
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  function automatic logic [31:0] jump_target(input logic [3:0]  pc_hi,
                                              input logic [25:0] addr);
    return {pc_hi, addr, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_pc.sv
// Program counter register and next-PC / redirect-target mux.
//   clk, rst_n     : clock, async active-low reset (pc -> RESET_PC)
//   advance        : pc <= pc + 4 (sequential fetch completed)
//   load_target    : pc <= target (redirect taken this cycle)
//   load_saved     : pc <= saved_target (deferred redirect completes)
//   jump           : select jump target over branch_target
//   jump_addr      : raw 26-bit J-format field
//   branch_target  : absolute branch address
//   pc_hi          : upper 4 bits of the held instruction's pc_plus4
//   saved_target   : redirect target parked while a stale fetch drains
//   pc             : current fetch address
//   target         : redirect target for this cycle
module instruction_fetch_pc
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        load_target,
  input  logic        load_saved,
  input  logic        jump,
  input  logic [25:0] jump_addr,
  input  logic [31:0] branch_target,
  input  logic [3:0]  pc_hi,
  input  logic [31:0] saved_target,
  output logic [31:0] pc,
  output logic [31:0] target
);

  logic [31:0] pc_next;

  always_comb begin
    target = jump ? jump_target(pc_hi, jump_addr) : branch_target;
  end

  // Priority: fresh redirect, then deferred redirect, then sequential step.
  always_comb begin
    pc_next = pc;
    if (load_target)     pc_next = target;
    else if (load_saved) pc_next = saved_target;
    else if (advance)    pc_next = pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: fetch FSM, one-entry skid buffer, output register.
//   clk, rst_n       : clock, async active-low reset
//   stall            : decode cannot accept a new instruction this cycle
//   branch_taken     : held instruction redirects to branch_target
//   branch_target    : absolute branch byte address
//   jump             : held instruction is J/JAL (wins over branch_taken)
//   jump_addr        : raw 26-bit J-format field
//   imem_req/addr    : fetch request and byte address (stable until imem_ready)
//   imem_ready/rdata : transfer completion and returned word
//   instruction      : registered instruction to decode
//   pc_plus4         : address of held instruction + 4
//   valid            : instruction/pc_plus4 are meaningful
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_inc;
  logic [31:0]  target;
  logic [31:0]  saved_target;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc4;
  logic         redirect;
  logic         pc_advance;
  logic         pc_load_target;
  logic         pc_load_saved;

  assign redirect  = valid && !stall && (jump || branch_taken);
  assign pc_inc    = pc + 32'd4;
  assign imem_req  = (state == REQ) || (state == DISCARD);
  // In DISCARD the pc is left untouched, so the in-flight address stays put.
  assign imem_addr = pc;

  always_comb begin
    pc_advance     = 1'b0;
    pc_load_target = 1'b0;
    pc_load_saved  = 1'b0;
    unique case (state)
      REQ: begin
        pc_advance     = imem_ready && !redirect;
        pc_load_target = imem_ready && redirect;
      end
      HOLD:    pc_load_target = redirect;
      DISCARD: begin
        pc_load_target = imem_ready && redirect;
        pc_load_saved  = imem_ready && !redirect;
      end
      default: ;
    endcase
  end

  instruction_fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst_n         (rst_n),
    .advance       (pc_advance),
    .load_target   (pc_load_target),
    .load_saved    (pc_load_saved),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .branch_target (branch_target),
    .pc_hi         (pc_plus4[31:28]),
    .saved_target  (saved_target),
    .pc            (pc),
    .target        (target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      instruction  <= '0;
      pc_plus4     <= '0;
      valid        <= 1'b0;
      skid_instr   <= '0;
      skid_pc4     <= '0;
      saved_target <= '0;
    end else begin
      unique case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (redirect) begin
            // Word returned alongside a redirect is wrong-path; drop it.
            valid <= 1'b0;
            if (!imem_ready) begin
              saved_target <= target;
              state        <= DISCARD;
            end
          end else if (imem_ready) begin
            if (stall && valid) begin
              skid_instr <= imem_rdata;
              skid_pc4   <= pc_inc;
              state      <= HOLD;
            end else begin
              instruction <= imem_rdata;
              pc_plus4    <= pc_inc;
              valid       <= 1'b1;
            end
          end else if (!stall) begin
            // Current word consumed and nothing new arrived.
            valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            valid <= 1'b0;
            state <= REQ;
          end else if (!stall) begin
            instruction <= skid_instr;
            pc_plus4    <= skid_pc4;
            state       <= REQ;
          end
        end
        DISCARD: begin
          if (imem_ready)    state        <= REQ;
          else if (redirect) saved_target <= target;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic        valid;

  int errors = 0;
  int checks = 0;

  // Memory model: each word encodes its own address.
  assign imem_rdata = {8'hA5, imem_addr[23:0]};

  instruction_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc_plus4      (pc_plus4),
    .valid         (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, then one cycle through BOOT so the FSM sits in REQ at pc 0.
  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_addr = '0; imem_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_addr = '0; imem_ready = 1'b1;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instruction); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h want 0", pc_plus4); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL boot_to_req got %b want 1", imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc4 [3] = '{32'd4, 32'd8, 32'd12};
    do_reset();
    checks++; if (imem_addr !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL seq_first addr %h valid %b want 0/0", imem_addr, valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || pc_plus4 !== exp_pc4[i] || imem_addr !== exp_pc4[i] ||
          instruction !== {8'hA5, 24'(exp_pc4[i] - 32'd4)}) begin
        errors++;
        $display("FAIL seq_%0d valid %b pc4 %h addr %h instr %h want 1/%h/%h", i, valid, pc_plus4,
                 imem_addr, instruction, exp_pc4[i], exp_pc4[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();  // word @0 on output, fetch @4 pending
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b0 || instruction !== 32'hA500_0000 || pc_plus4 !== 32'd4 || valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d req %b instr %h pc4 %h valid %b want 0/a5000000/4/1", i,
                 imem_req, instruction, pc_plus4, valid);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (instruction !== 32'hA500_0004 || pc_plus4 !== 32'd8 || imem_req !== 1'b1 || imem_addr !== 32'd8) begin
      errors++;
      $display("FAIL stall_skid instr %h pc4 %h req %b addr %h want a5000004/8/1/8", instruction,
               pc_plus4, imem_req, imem_addr);
    end
    step();
    checks++;
    if (instruction !== 32'hA500_0008 || pc_plus4 !== 32'd12) begin
      errors++;
      $display("FAIL stall_after instr %h pc4 %h want a5000008/c", instruction, pc_plus4);
    end
  endtask

  task automatic test_jump();
    do_reset();
    step();
    branch_taken = 1'b1; branch_target = 32'h4000_000C;
    step();
    branch_taken = 1'b0;
    checks++; if (imem_addr !== 32'h4000_000C || valid !== 1'b0) begin errors++; $display("FAIL jmp_setup addr %h valid %b want 4000000c/0", imem_addr, valid); end
    step();
    checks++; if (pc_plus4 !== 32'h4000_0010 || valid !== 1'b1) begin errors++; $display("FAIL jmp_held pc4 %h valid %b want 40000010/1", pc_plus4, valid); end
    jump = 1'b1; jump_addr = 26'h0000100;
    step();
    jump = 1'b0;
    checks++; if (imem_addr !== 32'h4000_0400 || valid !== 1'b0) begin errors++; $display("FAIL jmp_target addr %h valid %b want 40000400/0", imem_addr, valid); end
    step();
    checks++;
    if (valid !== 1'b1 || instruction !== 32'hA500_0400 || pc_plus4 !== 32'h4000_0404) begin
      errors++;
      $display("FAIL jmp_fetch valid %b instr %h pc4 %h want 1/a5000400/40000404", valid, instruction, pc_plus4);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    step();
    checks++;
    if (pc_plus4 !== 32'h0 || imem_addr !== 32'h0 || instruction !== 32'hA5FF_FFFC || valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap pc4 %h addr %h instr %h valid %b want 0/0/a5fffffc/1", pc_plus4, imem_addr,
               instruction, valid);
    end
  endtask

  task automatic test_branch_wait();
    do_reset();
    step();
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0080;
    step();
    branch_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'd4 || valid !== 1'b0) begin
        errors++;
        $display("FAIL br_wait_%0d req %b addr %h valid %b want 1/4/0", i, imem_req, imem_addr, valid);
      end
      if (i < 3) step();
    end
    imem_ready = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h80 || valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL br_drop addr %h valid %b req %b want 80/0/1", imem_addr, valid, imem_req); end
    step();
    checks++;
    if (instruction !== 32'hA500_0080 || pc_plus4 !== 32'h84 || valid !== 1'b1) begin
      errors++;
      $display("FAIL br_fetch instr %h pc4 %h valid %b want a5000080/84/1", instruction, pc_plus4, valid);
    end
  endtask

  task automatic test_priority();
    do_reset();
    step();
    jump = 1'b1; jump_addr = 26'h10; branch_taken = 1'b1; branch_target = 32'h200;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL prio_jump addr %h want 40", imem_addr); end
    step();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
    step();
    checks++;
    if (imem_req !== 1'b0 || instruction !== 32'hA500_0040 || valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_redirect req %b instr %h valid %b want 0/a5000040/1", imem_req, instruction, valid);
    end
    branch_taken = 1'b0; stall = 1'b0;
    step();
    checks++;
    if (instruction !== 32'hA500_0044 || pc_plus4 !== 32'h48 || imem_addr !== 32'h48) begin
      errors++;
      $display("FAIL stall_redirect_after instr %h pc4 %h addr %h want a5000044/48/48", instruction,
               pc_plus4, imem_addr);
    end
  endtask

  task automatic test_reset_discard();
    do_reset();
    step();
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h80;
    step();
    branch_taken = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin errors++; $display("FAIL rd_pre req %b addr %h want 1/4", imem_req, imem_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instruction !== 32'h0 || pc_plus4 !== 32'h0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_async req %b addr %h instr %h pc4 %h valid %b want all 0", imem_req, imem_addr,
               instruction, pc_plus4, valid);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rd_restart req %b addr %h want 1/0", imem_req, imem_addr); end
    imem_ready = 1'b1;
    step();
    checks++; if (instruction !== 32'hA500_0000 || valid !== 1'b1) begin errors++; $display("FAIL rd_first instr %h valid %b want a5000000/1", instruction, valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_wrap();
    test_branch_wait();
    test_priority();
    test_reset_discard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
